// File: rtl/mux_arb_pkg.sv
// Shared constants and types for the N:1 arbitrated writeback mux.
// Mode encodings, counter width, default sizes and the output-register state type.
package mux_arb_pkg;

   localparam logic MODE_SEL        = 1'b0;
   localparam logic MODE_RR         = 1'b1;
   localparam int   CNT_WIDTH       = 16;
   localparam int   DEF_DATA_LENGTH = 32;
   localparam int   DEF_NUM_INPUTS  = 4;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_t;

endpackage

// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter: pointer register plus wrap-around priority search from pointer+1.
// Grant is combinational (0 cycles); the pointer advances only when i_update is asserted.
module rr_arbiter_n #(
   parameter int N     = 4,
   parameter int SEL_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     i_req,
   input  logic             i_update,
   output logic             o_grant_vld,
   output logic [SEL_W-1:0] o_grant_idx
);

   logic [SEL_W-1:0] r_ptr;
   logic             w_hi_found;
   logic             w_lo_found;
   logic [SEL_W-1:0] w_hi_idx;
   logic [SEL_W-1:0] w_lo_idx;

   // Lowest requester above the pointer wins; otherwise wrap to the lowest at or below it.
   always_comb begin
      w_hi_found = 1'b0;
      w_lo_found = 1'b0;
      w_hi_idx   = '0;
      w_lo_idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            if (i > int'(r_ptr)) begin
               w_hi_found = 1'b1;
               w_hi_idx   = SEL_W'(i);
            end else begin
               w_lo_found = 1'b1;
               w_lo_idx   = SEL_W'(i);
            end
         end
      end
   end

   assign o_grant_vld = w_hi_found || w_lo_found;
   assign o_grant_idx = w_hi_found ? w_hi_idx : w_lo_idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= SEL_W'(N - 1);
      end else if (i_update && o_grant_vld) begin
         r_ptr <= o_grant_idx;
      end
   end

endmodule

// File: rtl/mux_n_1_arb.sv
// N:1 mux with explicit-select or round-robin grant into a 1-cycle output register; full throughput.
// Backpressure: in_ready only when the register is empty or popping; optional MUX_N_1_ARB_COUNT_EN adds per-channel grant counters.
module mux_n_1_arb
   import mux_arb_pkg::*;
#(
   parameter int DATA_LENGTH = DEF_DATA_LENGTH,
   parameter int NUM_INPUTS  = DEF_NUM_INPUTS,
   parameter int SEL_LENGTH  = $clog2(NUM_INPUTS)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              mode,
   input  logic [SEL_LENGTH-1:0]             sel,
   input  logic [NUM_INPUTS*DATA_LENGTH-1:0] in_data,
   input  logic [NUM_INPUTS-1:0]             in_valid,
   output logic [NUM_INPUTS-1:0]             in_ready,
   output logic [DATA_LENGTH-1:0]            out_data,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [SEL_LENGTH-1:0]             out_src
`ifdef MUX_N_1_ARB_COUNT_EN
   ,
   output logic [NUM_INPUTS*CNT_WIDTH-1:0]   grant_cnt
`endif
);

   out_state_t             r_state;
   out_state_t             w_state_nxt;
   logic [DATA_LENGTH-1:0] r_out_data;
   logic [SEL_LENGTH-1:0]  r_out_src;

   logic [DATA_LENGTH-1:0] w_ch [NUM_INPUTS];
   logic                   w_load_en;
   logic                   w_sel_in_range;
   logic                   w_sel_vld;
   logic                   w_rr_vld;
   logic [SEL_LENGTH-1:0]  w_rr_idx;
   logic                   w_grant_vld;
   logic [SEL_LENGTH-1:0]  w_grant_idx;
   logic                   w_hs;

   for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_unpack
      assign w_ch[g] = in_data[g*DATA_LENGTH +: DATA_LENGTH];
   end

   // Only non-power-of-two channel counts can see an out-of-range sel.
   if ((1 << SEL_LENGTH) > NUM_INPUTS) begin : g_sel_chk
      assign w_sel_in_range = (sel < SEL_LENGTH'(NUM_INPUTS));
   end else begin : g_sel_full
      assign w_sel_in_range = 1'b1;
   end

   assign out_valid = (r_state == ST_FULL);
   assign w_load_en = !rst && (!out_valid || out_ready);
   assign w_sel_vld = w_sel_in_range && in_valid[sel];

   rr_arbiter_n #(
      .N     (NUM_INPUTS),
      .SEL_W (SEL_LENGTH)
   ) u_rr (
      .clk         (clk),
      .rst         (rst),
      .i_req       (in_valid),
      .i_update    (w_load_en && (mode == MODE_RR)),
      .o_grant_vld (w_rr_vld),
      .o_grant_idx (w_rr_idx)
   );

   assign w_grant_vld = (mode == MODE_RR) ? w_rr_vld : w_sel_vld;
   assign w_grant_idx = (mode == MODE_RR) ? w_rr_idx : sel;
   assign w_hs        = w_load_en && w_grant_vld;

   always_comb begin
      in_ready = '0;
      if (w_hs) begin
         in_ready[w_grant_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_EMPTY: if (w_hs)               w_state_nxt = ST_FULL;
         ST_FULL:  if (out_ready && !w_hs) w_state_nxt = ST_EMPTY;
         default:                          w_state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_data <= '0;
         r_out_src  <= '0;
      end else if (w_hs) begin
         r_out_data <= w_ch[w_grant_idx];
         r_out_src  <= w_grant_idx;
      end
   end

   assign out_data = r_out_data;
   assign out_src  = r_out_src;

`ifdef MUX_N_1_ARB_COUNT_EN
   logic [CNT_WIDTH-1:0] r_cnt [NUM_INPUTS];

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
         if (rst) begin
            r_cnt[i] <= '0;
         end else if (in_ready[i] && (r_cnt[i] != '1)) begin
            r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
         end
      end
   end

   for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_cnt_out
      assign grant_cnt[g*CNT_WIDTH +: CNT_WIDTH] = r_cnt[g];
   end
`endif

endmodule

// File: tb/tb_mux_n_1_arb.sv
// Directed bench for mux_n_1_arb: a 4-input and a 5-input instance, checked with immediate assertions.
module tb_mux_n_1_arb;
   import mux_arb_pkg::*;

   logic         clk = 1'b0;
   logic         rst;

   logic         mode4;
   logic [1:0]   sel4;
   logic [127:0] in_data4;
   logic [3:0]   in_valid4;
   logic [3:0]   in_ready4;
   logic [31:0]  out_data4;
   logic         out_valid4;
   logic         out_ready4;
   logic [1:0]   out_src4;

   logic         mode5;
   logic [2:0]   sel5;
   logic [159:0] in_data5;
   logic [4:0]   in_valid5;
   logic [4:0]   in_ready5;
   logic [31:0]  out_data5;
   logic         out_valid5;
   logic         out_ready5;
   logic [2:0]   out_src5;

`ifdef MUX_N_1_ARB_COUNT_EN
   logic [4*CNT_WIDTH-1:0] grant_cnt4;
   logic [5*CNT_WIDTH-1:0] grant_cnt5;
`endif

   logic [31:0] ch_dat [4];
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   mux_n_1_arb #(.DATA_LENGTH(32), .NUM_INPUTS(4)) u_dut4 (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode4),
      .sel       (sel4),
      .in_data   (in_data4),
      .in_valid  (in_valid4),
      .in_ready  (in_ready4),
      .out_data  (out_data4),
      .out_valid (out_valid4),
      .out_ready (out_ready4),
      .out_src   (out_src4)
`ifdef MUX_N_1_ARB_COUNT_EN
      ,
      .grant_cnt (grant_cnt4)
`endif
   );

   mux_n_1_arb #(.DATA_LENGTH(32), .NUM_INPUTS(5)) u_dut5 (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode5),
      .sel       (sel5),
      .in_data   (in_data5),
      .in_valid  (in_valid5),
      .in_ready  (in_ready5),
      .out_data  (out_data5),
      .out_valid (out_valid5),
      .out_ready (out_ready5),
      .out_src   (out_src5)
`ifdef MUX_N_1_ARB_COUNT_EN
      ,
      .grant_cnt (grant_cnt5)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Registered outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      ch_dat[0] = 32'h0000_0011;
      ch_dat[1] = 32'h2222_0001;
      ch_dat[2] = 32'hDEAD_BEEF;
      ch_dat[3] = 32'h3333_0003;
      in_data4  = {ch_dat[3], ch_dat[2], ch_dat[1], ch_dat[0]};
      in_data5  = {32'h5555_0004, 32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};

      rst        = 1'b1;
      mode4      = MODE_SEL;
      sel4       = 2'd0;
      in_valid4  = 4'b1111;
      out_ready4 = 1'b1;
      mode5      = MODE_SEL;
      sel5       = 3'd0;
      in_valid5  = 5'b0;
      out_ready5 = 1'b1;

      // Reset state
      tick();
      tick();
      check("rst_out_valid", out_valid4, 0);
      check("rst_out_data", out_data4, 0);
      check("rst_out_src", out_src4, 0);
      check("rst_in_ready", in_ready4, 0);

      // Explicit select of channel 2
      rst       = 1'b0;
      sel4      = 2'd2;
      in_valid4 = 4'b0100;
      #1;
      check("sel2_in_ready", in_ready4, 4'b0100);
      tick();
      check("sel2_out_valid", out_valid4, 1);
      check("sel2_out_data", out_data4, 32'hDEAD_BEEF);
      check("sel2_out_src", out_src4, 2);

      in_valid4 = 4'b0000;
      tick();
      check("pop_out_valid", out_valid4, 0);

      // Round-robin, all valid: the select grant must not have moved the pointer
      mode4     = MODE_RR;
      in_valid4 = 4'b1111;
      #1;
      check("rr_first_in_ready", in_ready4, 4'b0001);
      for (int k = 0; k < 8; k++) begin
         tick();
         check("rr_out_valid", out_valid4, 1);
         check("rr_out_src", out_src4, k % 4);
         check("rr_out_data", out_data4, ch_dat[k % 4]);
      end

      // Backpressure: hold 32'h11 while channel 1 waits
      mode4     = MODE_SEL;
      sel4      = 2'd0;
      in_valid4 = 4'b0001;
      tick();
      check("bp_load_data", out_data4, 32'h11);
      out_ready4 = 1'b0;
      sel4       = 2'd1;
      in_valid4  = 4'b0010;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("bp_in_ready", in_ready4, 0);
         tick();
         check("bp_hold_data", out_data4, 32'h11);
         check("bp_hold_src", out_src4, 0);
      end
      out_ready4 = 1'b1;
      #1;
      check("bp_release_in_ready", in_ready4, 4'b0010);
      tick();
      check("bp_release_data", out_data4, ch_dat[1]);
      check("bp_release_src", out_src4, 1);
      in_valid4 = 4'b0000;
      tick();
      check("bp_drain_valid", out_valid4, 0);

      // Round-robin with sparse requests wraps 1 -> 3 -> 1
      mode4     = MODE_RR;
      in_valid4 = 4'b1010;
      #1;
      check("rr_sparse_in_ready", in_ready4, 4'b0010);
      tick();
      check("rr_sparse_src0", out_src4, 1);
      tick();
      check("rr_sparse_src1", out_src4, 3);
      tick();
      check("rr_sparse_src2", out_src4, 1);

      // Reset mid-transfer discards the held word and restores channel 0 priority
      rst = 1'b1;
      #1;
      check("midrst_in_ready", in_ready4, 0);
      tick();
      check("midrst_out_valid", out_valid4, 0);
      check("midrst_out_data", out_data4, 0);
      check("midrst_out_src", out_src4, 0);
      rst       = 1'b0;
      in_valid4 = 4'b1111;
      #1;
      check("midrst_rr_in_ready", in_ready4, 4'b0001);
      tick();
      check("midrst_rr_src", out_src4, 0);
      check("midrst_rr_valid", out_valid4, 1);
      in_valid4 = 4'b0000;
      tick();

      // Five-input instance: out-of-range select never grants
      sel5      = 3'd5;
      in_valid5 = 5'b11111;
      #1;
      check("sel5_in_ready", in_ready5, 0);
      tick();
      check("sel5_out_valid", out_valid5, 0);
      sel5 = 3'd7;
      #1;
      check("sel7_in_ready", in_ready5, 0);
      tick();
      check("sel7_out_valid", out_valid5, 0);
      sel5 = 3'd4;
      #1;
      check("sel4_in_ready", in_ready5, 5'b10000);
      tick();
      check("sel4_out_valid", out_valid5, 1);
      check("sel4_out_src", out_src5, 4);
      check("sel4_out_data", out_data5, 32'h5555_0004);
      in_valid5 = 5'b0;
      tick();

`ifdef MUX_N_1_ARB_COUNT_EN
      rst = 1'b1;
      tick();
      check("cnt_rst", grant_cnt4[15:0], 0);
      rst       = 1'b0;
      mode4     = MODE_SEL;
      sel4      = 2'd0;
      in_valid4 = 4'b0001;
      repeat (3) @(posedge clk);
      #1;
      in_valid4 = 4'b0000;
      check("cnt_three", grant_cnt4[15:0], 3);
      check("cnt_other", grant_cnt4[31:16], 0);
      in_valid4 = 4'b0001;
      repeat (65532) @(posedge clk);
      #1;
      check("cnt_full", grant_cnt4[15:0], 16'hFFFF);
      tick();
      in_valid4 = 4'b0000;
      check("cnt_saturate", grant_cnt4[15:0], 16'hFFFF);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mux_n_1_arb.md
Name: mux_n_1_arb

Overview:
- Parametrised N:1 datapath multiplexer for the multi-cycle MIPS core; generalises the 2:1 select mux.
- Adds a registered output stage with valid/ready handshaking on every input and on the output.
- Two select modes: explicit select (sel port) or round-robin arbitration across valid inputs.
- Used where several producers (e.g. memory/ALU/CP0 writeback sources) share one consumer port.

Parameters:
- DATA_LENGTH, 32, width of each data channel in bits.
- NUM_INPUTS, 4, number of input channels (2..16).
- SEL_LENGTH, $clog2(NUM_INPUTS), select/source index width; derived, must not be overridden.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  reset; synchronous and active-high.
- mode  input  1  0 = explicit select (MODE_SEL), 1 = round-robin (MODE_RR).
- sel  input  SEL_LENGTH  channel index used in MODE_SEL.
- in_data  input  NUM_INPUTS*DATA_LENGTH  flattened inputs; channel i occupies bits [i*DATA_LENGTH +: DATA_LENGTH].
- in_valid  input  NUM_INPUTS  per-channel valid.
- in_ready  output  NUM_INPUTS  per-channel accept; combinational.
- out_data  output  DATA_LENGTH  registered selected data.
- out_valid  output  1  output register holds data.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_src  output  SEL_LENGTH  index of the channel that supplied out_data.

Behaviour:
- Reset (rst=1 at clk edge): out_valid=0, out_data=0, out_src=0, RR pointer=NUM_INPUTS-1, so channel 0 has first priority. in_ready=0 while rst=1.
- Output register FSM, two states:
  - EMPTY (out_valid=0) -> FULL when a grant occurs.
  - FULL -> EMPTY when out_ready=1 and no grant occurs.
  - FULL -> FULL when out_ready=1 with a grant (back-to-back transfer), or when out_ready=0 (hold; out_data/out_src stable).
- load_en = !out_valid || out_ready. Throughput is 1 transfer/cycle; latency is 1 cycle from in handshake to out_valid.
- MODE_SEL:
  - Grant channel sel iff in_valid[sel]=1.
  - sel >= NUM_INPUTS gives no grant, and all in_ready=0.
- MODE_RR:
  - Search from pointer+1 upward with wrap-around; grant the first channel with in_valid=1.
  - On a grant (with load_en) the pointer updates to the granted index. The pointer is held otherwise, including in MODE_SEL.
- in_ready[i] = load_en && grant_valid && (grant==i); at most one bit is set (one-hot or zero).
- On a handshake: out_data <= channel data, out_src <= grant index, out_valid <= 1.
- A mode or sel change takes effect on the next grant evaluation; a held output is never altered.
- No valid inputs: no grant and no state change except the pop.
- Reset mid-transfer: any held output is discarded with no further handshakes.

Optional Feature:
- Macro: MUX_N_1_ARB_COUNT_EN.
- Defined: adds output port grant_cnt (NUM_INPUTS*CNT_WIDTH). Each channel has a counter that increments on its handshake, saturates at all-ones, and is cleared to 0 by rst.
- Undefined: the port and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Package mux_arb_pkg holds MODE_SEL=1'b0, MODE_RR=1'b1, CNT_WIDTH=16, and the default DATA_LENGTH/NUM_INPUTS constants.
- One sub-module, rr_arbiter_n. It contains the round-robin pointer register and the combinational wrap-around priority search, and outputs grant_valid and the grant index. The top level keeps the select-mode logic, handshakes and output register.

Test Plan:
- MODE_SEL, sel=2, in_valid=4'b0100, in_data ch2=32'hDEADBEEF, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=32'hDEADBEEF, out_src=2.
- MODE_RR, in_valid=4'b1111 held, out_ready=1 for 8 cycles after reset -> grants in order 0,1,2,3,0,1,2,3, one per cycle.
- Backpressure: out FULL with 32'h11, out_ready=0 for 3 cycles, ch1 valid -> in_ready=0, out_data stays 32'h11; on out_ready=1, ch1 is loaded the same cycle.
- sel=3'd5 with NUM_INPUTS=5, all valid -> no grant, out_valid remains 0.
- Reset mid-operation: out FULL, assert rst one cycle -> out_valid=0, out_data=0, out_src=0, next RR grant goes to channel 0.
- MUX_N_1_ARB_COUNT_EN defined: 3 handshakes on ch0 -> grant_cnt[0]=3. Counter preloaded to 16'hFFFF stays 16'hFFFF after a further handshake.
